// File: rtl/video_timing_generator.sv
// Raster timing generator: sync/active decode, start pulses and letterboxed
// pixel-replicated source coordinates. Define VTG_FRAME_COUNTER_EN to add frame_cnt.
module video_timing_generator #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int SRC_W     = 160,
  parameter int SRC_H     = 120,
  parameter int SCALE     = 4,
  parameter int H_OFFSET  = 80,
  parameter int V_OFFSET  = 60
) (
  input  logic                          CLK_40,
  input  logic                          reset,
  input  logic                          clk_en,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          active,
  output logic [$clog2(H_ACTIVE)-1:0]   x_pos,
  output logic [$clog2(V_ACTIVE)-1:0]   y_pos,
  output logic                          line_start,
  output logic                          frame_start,
  output logic [$clog2(SRC_W+1)-1:0]    src_x,
  output logic [$clog2(SRC_H+1)-1:0]    src_y,
  output logic                          src_valid
`ifdef VTG_FRAME_COUNTER_EN
  , output logic [15:0]                 frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int SXW     = $clog2(SRC_W + 1);
  localparam int SYW     = $clog2(SRC_H + 1);
  localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int H_WIN_E = H_OFFSET + SRC_W * SCALE;
  localparam int V_WIN_E = V_OFFSET + SRC_H * SCALE;

  localparam logic [HW-1:0]    H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [SUB_W-1:0] SUB_L   = SUB_W'(SCALE - 1);
  localparam logic [SXW-1:0]   SX_SAT  = SXW'(SRC_W);
  localparam logic [SYW-1:0]   SY_SAT  = SYW'(SRC_H);
  localparam logic             HS_ON   = (HSYNC_POL != 0);
  localparam logic             VS_ON   = (VSYNC_POL != 0);

  if (H_WIN_E > H_ACTIVE) begin : g_chk_h
    $error("source window exceeds H_ACTIVE");
  end
  if (V_WIN_E > V_ACTIVE) begin : g_chk_v
    $error("source window exceeds V_ACTIVE");
  end
  if (SCALE < 1) begin : g_chk_s
    $error("SCALE must be at least 1");
  end

  logic [HW-1:0]    h_cnt, h_nxt;
  logic [VW-1:0]    v_cnt, v_nxt;
  logic [SUB_W-1:0] h_sub, v_sub;
  logic             h_wrap, f_wrap, act_nxt, h_in, v_in, hwin_nxt, vwin_nxt;

  // Outputs are decoded from the next counter value so they line up with the counters.
  always_comb begin
    h_wrap   = (h_cnt == H_LAST);
    f_wrap   = h_wrap && (v_cnt == V_LAST);
    h_nxt    = h_wrap ? '0 : h_cnt + HW'(1);
    v_nxt    = v_cnt;
    if (h_wrap) v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    act_nxt  = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    hwin_nxt = (int'(h_nxt) >= H_OFFSET) && (int'(h_nxt) < H_WIN_E);
    vwin_nxt = (int'(v_nxt) >= V_OFFSET) && (int'(v_nxt) < V_WIN_E);
    h_in     = (int'(h_cnt) >= H_OFFSET) && (int'(h_cnt) < H_WIN_E);
    v_in     = (int'(v_cnt) >= V_OFFSET) && (int'(v_cnt) < V_WIN_E);
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hsync       <= !HS_ON;
      vsync       <= !VS_ON;
      active      <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      src_x       <= '0;
      src_y       <= '0;
      src_valid   <= 1'b0;
      h_sub       <= '0;
      v_sub       <= '0;
    end else if (clk_en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      active      <= act_nxt;
      x_pos       <= act_nxt ? XW'(h_nxt) : '0;
      y_pos       <= act_nxt ? YW'(v_nxt) : '0;
      hsync       <= ((int'(h_nxt) >= H_ACTIVE + H_FP) &&
                      (int'(h_nxt) < H_ACTIVE + H_FP + H_SYNC)) ? HS_ON : !HS_ON;
      vsync       <= ((int'(v_nxt) >= V_ACTIVE + V_FP) &&
                      (int'(v_nxt) < V_ACTIVE + V_FP + V_SYNC)) ? VS_ON : !VS_ON;
      line_start  <= h_wrap;
      frame_start <= f_wrap;
      src_valid   <= act_nxt && hwin_nxt && vwin_nxt;
      // Leaving a window pixel advances the replication count; a full count steps src_x.
      if (h_wrap) begin
        h_sub <= '0;
        src_x <= '0;
      end else if (h_in) begin
        if (h_sub == SUB_L) begin
          h_sub <= '0;
          if (src_x != SX_SAT) src_x <= src_x + SXW'(1);
        end else begin
          h_sub <= h_sub + SUB_W'(1);
        end
      end
      if (f_wrap) begin
        v_sub <= '0;
        src_y <= '0;
      end else if (h_wrap && v_in) begin
        if (v_sub == SUB_L) begin
          v_sub <= '0;
          if (src_y != SY_SAT) src_y <= src_y + SYW'(1);
        end else begin
          v_sub <= v_sub + SUB_W'(1);
        end
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VTG_FRAME_COUNTER_EN
  always_ff @(posedge CLK_40) begin
    if (reset)                 frame_cnt <= '0;
    else if (clk_en && f_wrap) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator on a shrunken raster, compared every cycle
// against a position-based arithmetic model of the timing rules.
module tb_video_timing_generator;

  localparam int HA = 40, HFP = 4, HS = 6, HBP = 5;
  localparam int VA = 30, VFP = 1, VS = 2, VBP = 3;
  localparam int HSP = 0, VSP = 1;
  localparam int SW = 8, SH = 6, SC = 3, HO = 7, VO = 5;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  logic CLK_40 = 1'b0;
  logic reset  = 1'b1;
  logic clk_en = 1'b0;
  logic hsync, vsync, active, line_start, frame_start, src_valid;
  logic [$clog2(HA)-1:0]   x_pos;
  logic [$clog2(VA)-1:0]   y_pos;
  logic [$clog2(SW+1)-1:0] src_x;
  logic [$clog2(SH+1)-1:0] src_y;
`ifdef VTG_FRAME_COUNTER_EN
  logic [15:0] frame_cnt;
`endif

  video_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(HSP), .VSYNC_POL(VSP),
    .SRC_W(SW), .SRC_H(SH), .SCALE(SC), .H_OFFSET(HO), .V_OFFSET(VO)
  ) dut (
    .CLK_40(CLK_40), .reset(reset), .clk_en(clk_en),
    .hsync(hsync), .vsync(vsync), .active(active),
    .x_pos(x_pos), .y_pos(y_pos),
    .line_start(line_start), .frame_start(frame_start),
    .src_x(src_x), .src_y(src_y), .src_valid(src_valid)
`ifdef VTG_FRAME_COUNTER_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  // Clock and reset
  always #5 CLK_40 = ~CLK_40;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mh, mv, m_fc;
  logic m_ls, m_fs;
  int fs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, pos %0d,%0d)", tag, got, exp, cyc, mh, mv);
    end
  endtask

  // Expected outputs derived directly from the model's raster position.
  task automatic compare_outputs(input logic was_rst);
    logic act, sv;
    act = (mh < HA) && (mv < VA);
    sv  = act && (mh >= HO) && (mh < HO + SW * SC) && (mv >= VO) && (mv < VO + SH * SC);
    check("active", active, act);
    check("x_pos", x_pos, act ? mh : 0);
    check("y_pos", y_pos, act ? mv : 0);
    check("hsync", hsync, (mh >= HA + HFP && mh < HA + HFP + HS) ? HSP : !HSP);
    check("vsync", vsync, (mv >= VA + VFP && mv < VA + VFP + VS) ? VSP : !VSP);
    check("line_start", line_start, m_ls);
    check("frame_start", frame_start, m_fs);
    check("src_valid", src_valid, sv);
    if (sv) begin
      check("src_x", src_x, (mh - HO) / SC);
      check("src_y", src_y, (mv - VO) / SC);
    end
    if (act && mh < HO) check("src_x_pre", src_x, 0);
    if (act && mh >= HO + SW * SC) check("src_x_sat", src_x, SW);
    if (act && mv < VO) check("src_y_pre", src_y, 0);
    if (act && mv >= VO + SH * SC) check("src_y_sat", src_y, SH);
    if (was_rst) begin
      check("rst_src_x", src_x, 0);
      check("rst_src_y", src_y, 0);
    end
`ifdef VTG_FRAME_COUNTER_EN
    check("frame_cnt", frame_cnt, m_fc);
`endif
  endtask

  // Driver: one CLK_40 cycle with the given enable and reset.
  task automatic step(input logic en, input logic rst);
    clk_en = en;
    reset  = rst;
    @(posedge CLK_40);
    cyc++;
    if (rst) begin
      mh = HT - 1; mv = VT - 1; m_ls = 1'b0; m_fs = 1'b0; m_fc = 0;
    end else if (en) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      m_ls = (mh == 0);
      m_fs = (mh == 0) && (mv == 0);
      if (m_fs) m_fc = (m_fc + 1) % 65536;
    end else begin
      m_ls = 1'b0; m_fs = 1'b0;
    end
    #1;
    compare_outputs(rst);
    if (frame_start) fs_q.push_back(cyc);
  endtask

  initial begin
    int hs_n, act_n, vs_n;
    mh = HT - 1; mv = VT - 1; m_ls = 1'b0; m_fs = 1'b0; m_fc = 0;

    // Reset, then a single enable enters (0,0).
    fs_q.delete();
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("first_fs", frame_start, 1);
    check("first_ls", line_start, 1);
    step(1'b0, 1'b0);
    check("fs_drop", frame_start, 0);

    // One line with continuous enable: sync and active widths.
    hs_n = 0; act_n = 0;
    for (int i = 0; i < HT; i++) begin
      step(1'b1, 1'b0);
      hs_n  += (hsync == HSP) ? 1 : 0;
      act_n += active ? 1 : 0;
    end
    check("hsync_width", hs_n, HS);
    check("active_width", act_n, HA);
    check("line_period", line_start, 1);

    // Rest of the frame: vsync lines and frame period.
    vs_n = 0;
    for (int i = 0; i < HT * VT + 3; i++) begin
      step(1'b1, 1'b0);
      if (line_start && vsync == VSP) vs_n++;
    end
    check("vsync_lines", vs_n, VS);
    check("fs_count", fs_q.size(), 2);
    if (fs_q.size() >= 2) check("frame_period", fs_q[1] - fs_q[0], HT * VT + 1);

    // Half-rate enable: frame period doubles, pulses stay one cycle.
    fs_q.delete();
    for (int i = 0; i < 4 * HT * VT + 8; i++) step((i % 2) == 0, 1'b0);
    check("fs_count_half", fs_q.size() >= 2, 1);
    if (fs_q.size() >= 2) check("frame_period_half", fs_q[1] - fs_q[0], 2 * HT * VT);

    // Random enable with rare resets.
    for (int i = 0; i < 6000; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 999) == 0);

    // Mid-frame reset at (20,15), then restart at (0,0).
    for (int i = 0; i < HT * VT && !(mh == 20 && mv == 15); i++) step(1'b1, 1'b0);
    check("reached_mid", (mh == 20 && mv == 15), 1);
    step(1'b1, 1'b1);
    check("mid_rst_active", active, 0);
    step(1'b1, 1'b0);
    check("mid_rst_fs", frame_start, 1);
    check("mid_rst_x", x_pos, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
